// File: rtl/bus_reg_file_if.sv
// Bus-side signal bundle for the general register file: write strobes, IR fields,
// drive selects and register readout. master = control/bus side, slave = register file.
interface bus_reg_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int CNT_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0]          BusMuxOut;
    logic [31:0]                    IR;
    logic                           Gra;
    logic                           Grb;
    logic                           Grc;
    logic                           Rin;
    logic                           Rout;
    logic                           BAout;
    logic [NUM_REGS-1:0]            RinDirect;
    logic [NUM_REGS-1:0]            RoutVec;
    logic [NUM_REGS*DATA_WIDTH-1:0] RegOut;
    logic                           WrValid;
    logic [3:0]                     WrIdx;
    logic [CNT_WIDTH-1:0]           WrCount;
    logic                           Collision;

    modport master (
        output BusMuxOut, IR, Gra, Grb, Grc, Rin, Rout, BAout, RinDirect,
        input  RoutVec, RegOut, WrValid, WrIdx, WrCount, Collision
    );

    modport slave (
        input  BusMuxOut, IR, Gra, Grb, Grc, Rin, Rout, BAout, RinDirect,
        output RoutVec, RegOut, WrValid, WrIdx, WrCount, Collision
    );
endinterface

// File: rtl/bus_reg_file.sv
// General register file R0-R15 at the sink end of the datapath bus.
// Optional macro BUS_REG_FILE_R0_HARDWIRED_EN makes R0 a constant zero.
module bus_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int CNT_WIDTH  = 8
) (
    input logic           clock,
    input logic           clear,
    bus_reg_file_if.slave bus
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [3:0]            sel;
    logic                  sel_valid;
    logic [NUM_REGS-1:0]   sel_onehot;
    logic [NUM_REGS-1:0]   wv;
    logic                  one_hot;
    logic                  multi;
    logic [3:0]            enc_idx;
    logic                  commit;
    logic                  wr_valid_q;
    logic [3:0]            wr_idx_q;
    logic [CNT_WIDTH-1:0]  wr_count_q;
    logic                  coll_q;
    logic                  unused_ir;

    assign unused_ir = ^{bus.IR[31:27], bus.IR[14:0]};

    // Register-field select, Gra has the highest priority
    always_comb begin
        sel       = 4'd0;
        sel_valid = bus.Gra | bus.Grb | bus.Grc;
        if (bus.Gra)
            sel = bus.IR[26:23];
        else if (bus.Grb)
            sel = bus.IR[22:19];
        else if (bus.Grc)
            sel = bus.IR[18:15];
    end

    assign sel_onehot = NUM_REGS'(1) << sel;
    assign wv         = bus.RinDirect | ((bus.Rin & sel_valid) ? sel_onehot : '0);

    // Clearing the lowest set bit leaves a nonzero value only when two or more are set
    assign multi   = (wv & (wv - NUM_REGS'(1))) != '0;
    assign one_hot = (wv != '0) && !multi;

    always_comb begin
        enc_idx = 4'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wv[i])
                enc_idx = 4'(i);
        end
    end

`ifdef BUS_REG_FILE_R0_HARDWIRED_EN
    assign commit = one_hot && (enc_idx != 4'd0);
`else
    assign commit = one_hot;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            wr_valid_q <= 1'b0;
            wr_idx_q   <= 4'd0;
            wr_count_q <= '0;
            coll_q     <= 1'b0;
        end else begin
            wr_valid_q <= commit;
            if (commit) begin
                regs[enc_idx] <= bus.BusMuxOut;
                wr_idx_q      <= enc_idx;
                wr_count_q    <= wr_count_q + CNT_WIDTH'(1);
            end
            if (multi)
                coll_q <= 1'b1;
        end
    end

    assign bus.RoutVec = ((bus.Rout | bus.BAout) & sel_valid) ? sel_onehot : '0;

    // Slice 0 reads as zero during a base-address drive
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++)
            bus.RegOut[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
`ifdef BUS_REG_FILE_R0_HARDWIRED_EN
        bus.RegOut[DATA_WIDTH-1:0] = '0;
`else
        if (bus.BAout)
            bus.RegOut[DATA_WIDTH-1:0] = '0;
`endif
    end

    assign bus.WrValid   = wr_valid_q;
    assign bus.WrIdx     = wr_idx_q;
    assign bus.WrCount   = wr_count_q;
    assign bus.Collision = coll_q;

endmodule

// File: tb/tb_bus_reg_file.sv
// Self-checking bench for bus_reg_file: directed steps plus random traffic,
// compared against an array-based reference model of the register file.
module tb_bus_reg_file;

    logic clock;
    logic clear;
    int   n_checks = 0;
    int   n_pass   = 0;

    bus_reg_file_if #(.DATA_WIDTH(32), .NUM_REGS(16), .CNT_WIDTH(8)) bus ();

    bus_reg_file #(.DATA_WIDTH(32), .NUM_REGS(16), .CNT_WIDTH(8)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [31:0] m_r [16];
    bit          m_valid;
    logic [3:0]  m_idx;
    logic [7:0]  m_cnt;
    bit          m_coll;
`ifdef BUS_REG_FILE_R0_HARDWIRED_EN
    localparam bit HARD_R0 = 1'b1;
`else
    localparam bit HARD_R0 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
        m_valid = 0;
        m_idx   = 4'd0;
        m_cnt   = 8'd0;
        m_coll  = 0;
    endtask

    function automatic void field_sel(output int s, output bit v);
        v = bus.Gra || bus.Grb || bus.Grc;
        if (bus.Gra)      s = int'(bus.IR[26:23]);
        else if (bus.Grb) s = int'(bus.IR[22:19]);
        else if (bus.Grc) s = int'(bus.IR[18:15]);
        else              s = 0;
    endfunction

    function automatic logic [15:0] exp_routvec();
        int s; bit v;
        field_sel(s, v);
        if ((bus.Rout || bus.BAout) && v) return 16'(1 << s);
        return 16'h0;
    endfunction

    function automatic logic [31:0] exp_slice(input int i);
        if (i == 0 && (HARD_R0 || bus.BAout)) return 32'h0;
        return m_r[i];
    endfunction

    // What the register file should do on one rising edge with clear high
    task automatic model_edge();
        int s; bit v; int wv; int n; int idx;
        field_sel(s, v);
        wv = int'(bus.RinDirect);
        if (bus.Rin && v) wv = wv | (1 << s);
        n = $countones(wv);
        idx = 0;
        for (int i = 0; i < 16; i++) if (wv[i]) idx = i;
        m_valid = 0;
        if (n >= 2) m_coll = 1;
        else if (n == 1 && !(HARD_R0 && idx == 0)) begin
            m_r[idx] = bus.BusMuxOut;
            m_idx    = 4'(idx);
            m_cnt    = m_cnt + 8'd1;
            m_valid  = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " RoutVec"}, 32'(bus.RoutVec), 32'(exp_routvec()));
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s RegOut[%0d]", tag, i), bus.RegOut[i*32 +: 32], exp_slice(i));
        chk({tag, " WrValid"},   32'(bus.WrValid),   32'(m_valid));
        chk({tag, " WrIdx"},     32'(bus.WrIdx),     32'(m_idx));
        chk({tag, " WrCount"},   32'(bus.WrCount),   32'(m_cnt));
        chk({tag, " Collision"}, 32'(bus.Collision), 32'(m_coll));
    endtask

    task automatic idle();
        bus.BusMuxOut = 32'h0;
        bus.IR        = 32'h0;
        bus.Gra = 0; bus.Grb = 0; bus.Grc = 0;
        bus.Rin = 0; bus.Rout = 0; bus.BAout = 0;
        bus.RinDirect = 16'h0;
    endtask

    // Called just after a falling edge with inputs already set
    task automatic step(input string tag);
        #1;
        check_all({tag, " pre"});
        @(posedge clock);
        model_edge();
        #1;
        check_all({tag, " post"});
        @(negedge clock);
    endtask

    // Asynchronous clear mid-cycle, held across one edge with a write pending
    task automatic async_clear();
        #2;
        clear = 1'b0;
        model_reset();
        #1;
        check_all("async clear");
        bus.RinDirect = 16'h0040;
        bus.BusMuxOut = 32'hA5A5A5A5;
        @(posedge clock);
        #1;
        check_all("clear over write");
        @(negedge clock);
        clear = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all("reset");
        clear = 1'b1;

        // Field write via Ra
        bus.IR = 32'(3) << 23; bus.Gra = 1; bus.Rin = 1; bus.BusMuxOut = 32'h12345678;
        step("field write");
        chk("R3 value", bus.RegOut[3*32 +: 32], 32'h12345678);
        chk("R3 WrValid", 32'(bus.WrValid), 32'h1);
        chk("R3 WrIdx", 32'(bus.WrIdx), 32'h3);
        chk("R3 WrCount", 32'(bus.WrCount), 32'h1);
        idle();
        step("after write");
        chk("WrValid drops", 32'(bus.WrValid), 32'h0);

        // Select priority
        bus.IR = (32'(2) << 23) | (32'(9) << 19); bus.Gra = 1; bus.Grb = 1; bus.Rout = 1;
        #1 chk("prio RoutVec", 32'(bus.RoutVec), 32'h0004);
        idle();
        bus.IR = 32'(15) << 15; bus.Grc = 1; bus.BAout = 1;
        #1 chk("Grc BAout RoutVec", 32'(bus.RoutVec), 32'h8000);
        step("grc baout");
        idle();

        // BAout gating of R0
        bus.RinDirect = 16'h0001; bus.BusMuxOut = 32'h00000042;
        step("write R0");
        idle();
        bus.Gra = 1; bus.BAout = 1;
        #1 chk("BAout RoutVec", 32'(bus.RoutVec), 32'h0001);
        chk("BAout slice0", bus.RegOut[31:0], 32'h0);
        bus.BAout = 0;
        #1 chk("plain slice0", bus.RegOut[31:0], HARD_R0 ? 32'h0 : 32'h42);
        step("r0 read");
        idle();

        // Collision is sticky through later valid writes
        bus.RinDirect = 16'h0011; bus.BusMuxOut = 32'hCAFEF00D;
        step("collision");
        chk("Collision set", 32'(bus.Collision), 32'h1);
        chk("R4 untouched", bus.RegOut[4*32 +: 32], 32'h0);
        bus.RinDirect = 16'h0100; bus.BusMuxOut = 32'h11112222;
        step("valid after collision");
        chk("Collision sticky", 32'(bus.Collision), 32'h1);
        idle();
        bus.Rin = 1; bus.BusMuxOut = 32'h77777777;
        step("rin without select");

        // Clear mid-run after writing R5
        bus.RinDirect = 16'h0020; bus.BusMuxOut = 32'hDEADBEEF;
        step("write R5");
        idle();
        async_clear();
        chk("cleared Collision", 32'(bus.Collision), 32'h0);
        bus.RinDirect = 16'h0004; bus.BusMuxOut = 32'h0BADF00D;
        step("first after clear");
        idle();

        // Counter wrap with back-to-back writes
        async_clear();
        for (int k = 0; k < 256; k++) begin
            bus.RinDirect = 16'(1 << (1 + (k % 15)));
            bus.BusMuxOut = 32'(k) * 32'h01010101;
            step("wrap");
        end
        chk("WrCount wrapped", 32'(bus.WrCount), 32'h0);
        bus.RinDirect = 16'h0200; bus.BusMuxOut = 32'h1;
        step("same reg 1");
        bus.BusMuxOut = 32'h2;
        step("same reg 2");
        chk("last wins", bus.RegOut[9*32 +: 32], 32'h2);
        idle();

        // Single write targeting R0
        bus.RinDirect = 16'h0001; bus.BusMuxOut = 32'hFFFFFFFF;
        step("r0 ones");
        chk("r0 ones slice0", bus.RegOut[31:0], HARD_R0 ? 32'h0 : 32'hFFFFFFFF);
        chk("r0 ones WrValid", 32'(bus.WrValid), HARD_R0 ? 32'h0 : 32'h1);
        idle();

        // Random traffic
        async_clear();
        for (int k = 0; k < 300; k++) begin
            int mode;
            bus.IR        = $urandom;
            bus.BusMuxOut = $urandom;
            bus.Gra   = ($urandom_range(0, 3) == 0);
            bus.Grb   = ($urandom_range(0, 3) == 0);
            bus.Grc   = ($urandom_range(0, 3) == 0);
            bus.Rout  = $urandom_range(0, 1);
            bus.BAout = ($urandom_range(0, 3) == 0);
            mode = $urandom_range(0, 15);
            bus.Rin = (mode < 6);
            if (mode >= 6 && mode < 14) bus.RinDirect = 16'(1 << $urandom_range(0, 15));
            else if (mode == 14)        bus.RinDirect = 16'($urandom);
            else                        bus.RinDirect = 16'h0;
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_reg_file.md
Name: bus_reg_file

Overview:
- Write (sink) end of the CPU datapath bus: captures BusMuxOut into one of the general registers R0-R15, selected by one-hot enables or by the IR register-field select/encode logic.
- Also produces the one-hot register-drive selects and the register values that feed the bus source mux.
- Sits between the bus and the control unit; the control unit drives the Gra/Grb/Grc/Rin/Rout/BAout strobes.

Parameters:
- DATA_WIDTH, 32, width of the bus and of each register.
- NUM_REGS, 16, number of general registers; fixed at 16 because the IR fields are 4 bits.
- CNT_WIDTH, 8, width of the write counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-low reset.
- BusMuxOut  input  DATA_WIDTH  bus value to be written.
- IR  input  32  instruction register; Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Gra, Grb, Grc  input  1 each  field-select strobes.
- Rin  input  1  write the field-selected register.
- Rout  input  1  drive the field-selected register onto the bus.
- BAout  input  1  base-address drive; like Rout, but R0 reads as zero.
- RinDirect  input  NUM_REGS  one-hot direct write enables, bit i selects Ri.
- RoutVec  output  NUM_REGS  one-hot register-drive selects to the bus mux.
- RegOut  output  NUM_REGS*DATA_WIDTH  flattened register values; slice i is Ri. Slice 0 is the BAout-gated R0.
- WrValid  output  1  registered pulse, high one cycle after a committed write.
- WrIdx  output  4  index of the last committed write.
- WrCount  output  CNT_WIDTH  number of committed writes; wraps.
- Collision  output  1  sticky flag: a write was rejected because more than one enable was set.

Behaviour:
- Field select (combinational), priority Gra > Grb > Grc:
  - sel = Ra if Gra, else Rb if Grb, else Rc if Grc.
  - selValid = Gra|Grb|Grc.
- Write vector: wv = RinDirect | ((Rin & selValid) ? onehot(sel) : 0).
- Commit on the rising clock edge:
  - wv has exactly one bit set: Ri <= BusMuxOut; WrIdx <= i; WrValid <= 1; WrCount <= WrCount+1 (wraps at 2^CNT_WIDTH-1 -> 0).
  - wv is zero: no register change; WrValid <= 0.
  - wv has two or more bits set: no register change; WrValid <= 0; Collision <= 1. Collision stays set until clear.
  - Rin asserted with selValid=0: treated as no write. Collision is not set.
- Latency:
  - A written value appears on RegOut slice i one cycle after the commit edge.
  - A read-during-write returns the old value in the same cycle.
- RoutVec (combinational): ((Rout|BAout) & selValid) ? onehot(sel) : 0.
- RegOut slice 0: forced to 0 while BAout=1; otherwise R0. Other slices are always the register contents.
- Reset: clear=0 asynchronously sets all Ri, WrIdx, WrCount to 0 and WrValid, Collision to 0.
- Reset mid-operation: clear overrides any write on the same edge. The first commit is allowed on the first rising edge after clear deasserts.
- Back-to-back writes to the same register on consecutive edges: the last one wins; each increments WrCount.

Optional Feature:
- Macro: BUS_REG_FILE_R0_HARDWIRED_EN.
- Defined:
  - R0 is constant zero; RegOut slice 0 is always 0.
  - A single-bit write to R0 commits nothing: no WrValid, no WrCount change, Collision unaffected.
  - A multi-bit wv including bit 0 still sets Collision.
- Undefined: R0 is an ordinary writable register, gated only by BAout as above.

Test Plan:
- Reset: clear=0 mid-run after writing R5=0xDEADBEEF -> RegOut all zero, WrCount=0, Collision=0 immediately, without waiting for a clock edge.
- Field write: IR with Ra=3, Gra=1, Rin=1, BusMuxOut=0x12345678, one edge:
  - R3=0x12345678 on the next cycle.
  - WrValid pulses one cycle; WrIdx=3; WrCount=1.
- Priority/select: Gra=Grb=1, Ra=2, Rb=9, Rout=1 -> RoutVec=0x0004. With Grc=1 only, Rc=15, BAout=1 -> RoutVec=0x8000.
- BAout gating: R0=0x00000042, BAout=1, sel=0 -> RoutVec=0x0001 and slice 0=0. With BAout=0, slice 0=0x42.
- Collision: RinDirect=0x0011 -> no register change, Collision=1 and stays 1 through subsequent valid writes. Clear resets it.
- Counter wrap and feature: 256 single writes with CNT_WIDTH=8 -> WrCount=0.
  - With BUS_REG_FILE_R0_HARDWIRED_EN: RinDirect=0x0001, BusMuxOut=0xFFFFFFFF -> slice 0 stays 0 and WrValid stays 0.
